// File: rtl/ed25519_pkg.sv
// Shared definitions for the ed25519 signing core register map and host sequencer.
// Constants only: no logic, no latency.
// No backpressure: pure declarations.
package ed25519_pkg;

   // Core register map
   localparam logic [7:0] ADDR_CTRL     = 8'h08;
   localparam logic [7:0] ADDR_STATUS   = 8'h09;
   localparam logic [7:0] ADDR_SECRET0  = 8'h10;
   localparam logic [7:0] ADDR_PUBLIC0  = 8'h20;
   localparam logic [7:0] ADDR_MESSAGE0 = 8'h30;
   localparam logic [7:0] ADDR_R0       = 8'h40;
   localparam logic [7:0] ADDR_S0       = 8'h50;

   // Bit positions inside CTRL and STATUS
   localparam int CTRL_START_BIT   = 0;
   localparam int STATUS_READY_BIT = 0;
   localparam int STATUS_DONE_BIT  = 1;

   // Core identification words ("ed25" "519 " "0.10")
   localparam logic [31:0] CORE_NAME0   = 32'h65643235;
   localparam logic [31:0] CORE_NAME1   = 32'h35313920;
   localparam logic [31:0] CORE_VERSION = 32'h302e3130;

   // Host sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRDY  = 3'd1,
      ST_WR    = 3'd2,
      ST_START = 3'd3,
      ST_PDONE = 3'd4,
      ST_RD    = 3'd5,
      ST_OUT   = 3'd6
   } state_e;

endpackage

// File: rtl/ed25519_reg_port.sv
// Single-access engine for the core register bus: one write or one read per request.
// Latency: write completes in its own cycle; read takes cycle A (cs) + cycle B (data).
// Backpressure: requester holds start/we/addr/wdata until done_o pulses.
module ed25519_reg_port (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        we_i,
   input  logic [7:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        cs_o,
   output logic        we_o,
   output logic [7:0]  address_o,
   output logic [31:0] write_data_o,
   input  logic [31:0] read_data_i,
   input  logic        error_i
);

   logic rd_b_q;   // high during cycle B of a read slot
   logic err_q;    // error captured at the end of read cycle A

   // Bus is only driven while an access is live; cycle B of a read keeps cs low.
   always_comb begin
      cs_o         = start_i && !rd_b_q;
      we_o         = cs_o && we_i;
      address_o    = cs_o ? addr_i : 8'h00;
      write_data_o = (cs_o && we_i) ? wdata_i : 32'h0;
      done_o       = (cs_o && we_i) || rd_b_q;
      err_o        = rd_b_q ? err_q : (cs_o && we_i && error_i);
      rdata_o      = read_data_i;
   end

   // Track read slot phase and hold the cycle-A error until the slot completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_b_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         rd_b_q <= cs_o && !we_i;
         if (cs_o && !we_i) begin
            err_q <= error_i;
         end
      end
   end

endmodule

// File: rtl/ed25519_sign_host.sv
// Sequences one signing job over the core register bus: poll ready, load, start, poll done, read R/S.
// Latency: 61 cycles capture-to-result when ready/done are set on the first poll.
// Backpressure: job_ready only in IDLE; result held with res_valid until res_ready.
module ed25519_sign_host
   import ed25519_pkg::*;
#(
   parameter int POLL_LIMIT = 65535
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_sk,
   input  logic [255:0] job_pk,
   input  logic [255:0] job_msg,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [255:0] res_r,
   output logic [255:0] res_s,
   output logic         res_err,
   output logic         res_timeout,
   output logic         cs,
   output logic         we,
   output logic [7:0]   address,
   output logic [31:0]  write_data,
   input  logic [31:0]  read_data,
   input  logic         error
);

   localparam int PW = $clog2(POLL_LIMIT + 1);

   state_e          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [PW-1:0]   poll_q, poll_d;
   logic [767:0]    ops_q, ops_d;     // {msg, pk, sk}: word n is the n-th operand write
   logic [511:0]    res_q, res_d;     // {s, r}: word n is the n-th result read
   logic            err_q, err_d;
   logic            tmo_q, tmo_d;

   logic            req_start, req_we;
   logic [7:0]      req_addr;
   logic [31:0]     req_wdata;
   logic            port_done, port_err;
   logic [31:0]     port_rdata;

   ed25519_reg_port u_port (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (req_start),
      .we_i         (req_we),
      .addr_i       (req_addr),
      .wdata_i      (req_wdata),
      .done_o       (port_done),
      .rdata_o      (port_rdata),
      .err_o        (port_err),
      .cs_o         (cs),
      .we_o         (we),
      .address_o    (address),
      .write_data_o (write_data),
      .read_data_i  (read_data),
      .error_i      (error)
   );

   // Translate the current state and word counter into a register access request.
   always_comb begin
      req_start = 1'b0;
      req_we    = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 32'h0;
      case (state_q)
         ST_PRDY, ST_PDONE: begin
            req_start = 1'b1;
            req_addr  = ADDR_STATUS;
         end
         ST_WR: begin
            req_start = 1'b1;
            req_we    = 1'b1;
            case (cnt_q[4:3])
               2'd0:    req_addr = ADDR_SECRET0;
               2'd1:    req_addr = ADDR_PUBLIC0;
               default: req_addr = ADDR_MESSAGE0;
            endcase
            req_addr  = req_addr + {5'b0, cnt_q[2:0]};
            req_wdata = ops_q[{cnt_q, 5'b0} +: 32];
         end
         ST_START: begin
            req_start = 1'b1;
            req_we    = 1'b1;
            req_addr  = ADDR_CTRL;
            req_wdata = 32'h1 << CTRL_START_BIT;
         end
         ST_RD: begin
            req_start = 1'b1;
            req_addr  = (cnt_q[3] ? ADDR_S0 : ADDR_R0) + {5'b0, cnt_q[2:0]};
         end
         default: ;
      endcase
   end

   // Job sequencing: advance on each completed access, bail to OUT on error or poll exhaustion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      poll_d  = poll_q;
      ops_d   = ops_q;
      res_d   = res_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (job_valid) begin
               ops_d   = {job_msg, job_pk, job_sk};
               res_d   = '0;
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               poll_d  = '0;
               state_d = ST_PRDY;
            end
         end
         ST_PRDY, ST_PDONE: begin
            if (port_done) begin
               if (port_err) begin
                  err_d   = 1'b1;
                  state_d = ST_OUT;
               end else if (port_rdata[(state_q == ST_PRDY) ? STATUS_READY_BIT : STATUS_DONE_BIT]) begin
                  cnt_d   = '0;
                  state_d = (state_q == ST_PRDY) ? ST_WR : ST_RD;
               end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
                  tmo_d   = 1'b1;
                  state_d = ST_OUT;
               end else begin
                  poll_d  = poll_q + PW'(1);
               end
            end
         end
         ST_WR: begin
            if (port_done) begin
               if (port_err) begin
                  err_d   = 1'b1;
                  state_d = ST_OUT;
               end else if (cnt_q == 5'd23) begin
                  state_d = ST_START;
               end else begin
                  cnt_d   = cnt_q + 5'd1;
               end
            end
         end
         ST_START: begin
            if (port_done) begin
               if (port_err) begin
                  err_d   = 1'b1;
                  state_d = ST_OUT;
               end else begin
                  poll_d  = '0;
                  state_d = ST_PDONE;
               end
            end
         end
         ST_RD: begin
            if (port_done) begin
               if (port_err) begin
                  err_d   = 1'b1;
                  state_d = ST_OUT;
               end else begin
                  res_d[{cnt_q[3:0], 5'b0} +: 32] = port_rdata;
                  if (cnt_q == 5'd15) begin
                     state_d = ST_OUT;
                  end else begin
                     cnt_d   = cnt_q + 5'd1;
                  end
               end
            end
         end
         ST_OUT: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight access immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         poll_q  <= '0;
         ops_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         poll_q  <= poll_d;
         ops_q   <= ops_d;
         res_q   <= res_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   assign job_ready   = (state_q == ST_IDLE);
   assign res_valid   = (state_q == ST_OUT);
   assign res_r       = res_q[255:0];
   assign res_s       = res_q[511:256];
   assign res_err     = err_q;
   assign res_timeout = tmo_q;

endmodule

// File: tb/tb_ed25519_sign_host.sv
// Directed bench for ed25519_sign_host with a behavioural register-core model.
// Second instance with POLL_LIMIT=4 exercises the done-poll timeout.
// Model responds on the falling edge so bus values are stable when observed.
module tb_ed25519_sign_host;

   localparam logic [255:0] R_EXP  = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
   localparam logic [255:0] S_EXP  = 256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000;
   localparam logic [255:0] SK_A   = 256'h1F2E3D4C_5B6A7988_97A6B5C4_D3E2F101_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   localparam logic [255:0] PK_A   = 256'hCAFEF00D_DEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_0BADC0DE_FACEB00C;
   localparam logic [255:0] MSG_A  = 256'h4D534738_4D534737_4D534736_4D534735_4D534734_4D534733_4D534732_4D534731;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         job_valid = 1'b0, job_ready;
   logic [255:0] job_sk = '0, job_pk = '0, job_msg = '0;
   logic         res_valid, res_ready = 1'b0;
   logic [255:0] res_r, res_s;
   logic         res_err, res_timeout;
   logic         cs, we;
   logic [7:0]   address;
   logic [31:0]  write_data;
   logic [31:0]  read_data = 32'h0;
   logic         error = 1'b0;

   logic         job_valid2 = 1'b0, job_ready2;
   logic         res_valid2, res_ready2 = 1'b0;
   logic [255:0] res_r2, res_s2;
   logic         res_err2, res_timeout2;
   logic         cs2, we2;
   logic [7:0]   address2;
   logic [31:0]  write_data2;
   logic [31:0]  read_data2 = 32'h1;   // always ready, never done
   logic         error2 = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // core model state
   int          ready_poll = 1, done_poll = 1, stat_n = 0, rs_n = 0, cons_viol = 0;
   bit          started = 1'b0, prev_rd = 1'b0;
   logic [7:0]  err_addr = 8'hFF;
   logic [40:0] trace[$];

   always #5 clk = ~clk;

   ed25519_sign_host u_dut (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
      .job_sk(job_sk), .job_pk(job_pk), .job_msg(job_msg),
      .res_valid(res_valid), .res_ready(res_ready), .res_r(res_r), .res_s(res_s),
      .res_err(res_err), .res_timeout(res_timeout),
      .cs(cs), .we(we), .address(address), .write_data(write_data),
      .read_data(read_data), .error(error)
   );

   ed25519_sign_host #(.POLL_LIMIT(4)) u_dut_to (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid2), .job_ready(job_ready2),
      .job_sk(job_sk), .job_pk(job_pk), .job_msg(job_msg),
      .res_valid(res_valid2), .res_ready(res_ready2), .res_r(res_r2), .res_s(res_s2),
      .res_err(res_err2), .res_timeout(res_timeout2),
      .cs(cs2), .we(we2), .address(address2), .write_data(write_data2),
      .read_data(read_data2), .error(error2)
   );

   // Behavioural core: logs every access, answers reads in cycle B, flags error on err_addr writes.
   always @(negedge clk) begin
      error = 1'b0;
      if (cs && !we && prev_rd) cons_viol++;
      prev_rd = cs && !we;
      if (cs) begin
         trace.push_back({we, address, we ? write_data : 32'h0});
         if (we) begin
            if (address == err_addr) error = 1'b1;
            if (address == 8'h08 && write_data == 32'h1) begin
               started = 1'b1;
               stat_n  = 0;
            end
         end else if (address == 8'h09) begin
            stat_n++;
            read_data = {30'b0, started && (stat_n >= done_poll), !started && (stat_n >= ready_poll)};
         end else if (address >= 8'h40 && address <= 8'h47) begin
            rs_n++;
            read_data = 32'h11111111 * (32'(address) - 32'h3F);
         end else if (address >= 8'h50 && address <= 8'h57) begin
            rs_n++;
            read_data = 32'hA0000000 + (32'(address) - 32'h50);
         end else begin
            read_data = 32'hDEADBEEF;
         end
      end
   end

   task automatic model_reset(input int rp, input int dp, input logic [7:0] ea);
      ready_poll = rp;
      done_poll  = dp;
      err_addr   = ea;
      started    = 1'b0;
      stat_n     = 0;
      rs_n       = 0;
      cons_viol  = 0;
      trace.delete();
   endtask

   task automatic submit(input logic [255:0] sk, input logic [255:0] pk, input logic [255:0] msg,
                         output int lat, output logic jr, output bit ok);
      @(negedge clk);
      job_sk = sk; job_pk = pk; job_msg = msg; job_valid = 1'b1;
      @(posedge clk); #1;
      job_valid = 1'b0;
      jr  = job_ready;
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(posedge clk); #1;
         lat++;
         if (res_valid) ok = 1'b1;
      end
   endtask

   task automatic accept();
      @(negedge clk); res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++; if (cs !== 1'b0)         begin n_err++; $display("FAIL reset_cs: got %b want 0", cs); end
      n_cmp++; if (we !== 1'b0)         begin n_err++; $display("FAIL reset_we: got %b want 0", we); end
      n_cmp++; if (address !== 8'h00)   begin n_err++; $display("FAIL reset_address: got %h want 00", address); end
      n_cmp++; if (write_data !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", write_data); end
      n_cmp++; if (job_ready !== 1'b1)  begin n_err++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
      n_cmp++; if (res_valid !== 1'b0)  begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      n_cmp++; if ({res_r, res_s} !== 512'h0) begin n_err++; $display("FAIL reset_result: got %h %h want 0", res_r, res_s); end
      n_cmp++; if ({res_err, res_timeout} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {res_err, res_timeout}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_full_job();
      int lat; logic jr; bit ok;
      logic [255:0] sk_v, pk_v, msg_v;
      logic [40:0]  exp_q[$];
      logic [7:0]   a;
      sk_v = SK_A; pk_v = PK_A; msg_v = MSG_A;
      for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 8'h09, 32'h0});
      for (int k = 0; k < 8; k++) begin a = 8'h10 + 8'(k); exp_q.push_back({1'b1, a, sk_v[32*k +: 32]}); end
      for (int k = 0; k < 8; k++) begin a = 8'h20 + 8'(k); exp_q.push_back({1'b1, a, pk_v[32*k +: 32]}); end
      for (int k = 0; k < 8; k++) begin a = 8'h30 + 8'(k); exp_q.push_back({1'b1, a, msg_v[32*k +: 32]}); end
      exp_q.push_back({1'b1, 8'h08, 32'h1});
      for (int k = 0; k < 10; k++) exp_q.push_back({1'b0, 8'h09, 32'h0});
      for (int k = 0; k < 8; k++) begin a = 8'h40 + 8'(k); exp_q.push_back({1'b0, a, 32'h0}); end
      for (int k = 0; k < 8; k++) begin a = 8'h50 + 8'(k); exp_q.push_back({1'b0, a, 32'h0}); end

      model_reset(3, 10, 8'hFF);
      submit(SK_A, PK_A, MSG_A, lat, jr, ok);
      n_cmp++; if (ok !== 1'b1)      begin n_err++; $display("FAIL full_res_valid: no result within bound"); end
      n_cmp++; if (jr !== 1'b0)      begin n_err++; $display("FAIL full_job_ready_drop: got %b want 0", jr); end
      n_cmp++; if (lat != 83)        begin n_err++; $display("FAIL full_latency: got %0d want 83", lat); end
      n_cmp++; if (res_r !== R_EXP)  begin n_err++; $display("FAIL full_res_r: got %h want %h", res_r, R_EXP); end
      n_cmp++; if (res_s !== S_EXP)  begin n_err++; $display("FAIL full_res_s: got %h want %h", res_s, S_EXP); end
      n_cmp++; if ({res_err, res_timeout} !== 2'b00) begin n_err++; $display("FAIL full_flags: got %b want 00", {res_err, res_timeout}); end
      n_cmp++; if (cons_viol != 0)   begin n_err++; $display("FAIL full_cs_gap: got %0d back-to-back read cs want 0", cons_viol); end
      n_cmp++; if (trace.size() != exp_q.size()) begin n_err++; $display("FAIL full_trace_len: got %0d want %0d", trace.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < trace.size(); i++) begin
         n_cmp++;
         if (trace[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL full_trace[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h", i,
                     trace[i][40], trace[i][39:32], trace[i][31:0], exp_q[i][40], exp_q[i][39:32], exp_q[i][31:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int nt;
      nt = trace.size();
      @(negedge clk);
      job_sk = ~SK_A; job_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_cmp++; if ({res_valid, job_ready} !== 2'b10) begin n_err++; $display("FAIL bp_handshake[%0d]: got valid/ready %b want 10", i, {res_valid, job_ready}); end
         n_cmp++; if ({res_r, res_s} !== {R_EXP, S_EXP}) begin n_err++; $display("FAIL bp_result[%0d]: got %h %h", i, res_r, res_s); end
      end
      job_valid = 1'b0;
      n_cmp++; if (trace.size() != nt) begin n_err++; $display("FAIL bp_no_job: got %0d accesses want %0d", trace.size(), nt); end
      accept();
      n_cmp++; if ({res_valid, job_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got valid/ready %b want 01", {res_valid, job_ready}); end
   endtask

   task automatic test_error();
      int lat; logic jr; bit ok; int nctrl;
      model_reset(1, 1, 8'h23);
      submit(SK_A, PK_A, MSG_A, lat, jr, ok);
      nctrl = 0;
      foreach (trace[i]) if (trace[i][40] && trace[i][39:32] == 8'h08) nctrl++;
      n_cmp++; if (ok !== 1'b1)        begin n_err++; $display("FAIL err_res_valid: no result within bound"); end
      n_cmp++; if (res_err !== 1'b1)   begin n_err++; $display("FAIL err_flag: got %b want 1", res_err); end
      n_cmp++; if (res_timeout !== 1'b0) begin n_err++; $display("FAIL err_timeout: got %b want 0", res_timeout); end
      n_cmp++; if (res_r !== 256'h0)   begin n_err++; $display("FAIL err_res_r: got %h want 0", res_r); end
      n_cmp++; if (nctrl != 0)         begin n_err++; $display("FAIL err_ctrl_write: got %0d want 0", nctrl); end
      n_cmp++; if (trace.size() != 13) begin n_err++; $display("FAIL err_access_count: got %0d want 13", trace.size()); end
      accept();
   endtask

   task automatic test_timeout();
      bit seen_ctrl, ok; int n_pd, n_rs;
      @(negedge clk); job_valid2 = 1'b1;
      @(posedge clk); #1; job_valid2 = 1'b0;
      seen_ctrl = 1'b0; ok = 1'b0; n_pd = 0; n_rs = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (cs2 && we2 && address2 == 8'h08) seen_ctrl = 1'b1;
         if (cs2 && !we2 && address2 == 8'h09 && seen_ctrl) n_pd++;
         if (cs2 && !we2 && address2 >= 8'h40) n_rs++;
         if (res_valid2) ok = 1'b1;
      end
      n_cmp++; if (ok !== 1'b1)          begin n_err++; $display("FAIL to_res_valid: no result within bound"); end
      n_cmp++; if (seen_ctrl !== 1'b1)   begin n_err++; $display("FAIL to_start: got %b want 1", seen_ctrl); end
      n_cmp++; if (n_pd != 4)            begin n_err++; $display("FAIL to_polls: got %0d want 4", n_pd); end
      n_cmp++; if (n_rs != 0)            begin n_err++; $display("FAIL to_result_reads: got %0d want 0", n_rs); end
      n_cmp++; if ({res_timeout2, res_err2} !== 2'b10) begin n_err++; $display("FAIL to_flags: got %b want 10", {res_timeout2, res_err2}); end
      @(negedge clk); res_ready2 = 1'b1;
      @(posedge clk); #1; res_ready2 = 1'b0;
   endtask

   task automatic test_reset_mid_rd();
      int lat; logic jr; bit ok;
      model_reset(1, 1, 8'hFF);
      @(negedge clk);
      job_sk = SK_A; job_pk = PK_A; job_msg = MSG_A; job_valid = 1'b1;
      @(posedge clk); #1; job_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (rs_n >= 5) ok = 1'b1;
      end
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_reach_rd: got %0d result reads want 5", rs_n); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({cs, we, address, write_data} !== 42'h0) begin n_err++; $display("FAIL rst_bus: got cs=%b we=%b a=%h d=%h want 0", cs, we, address, write_data); end
      n_cmp++; if ({job_ready, res_valid} !== 2'b10) begin n_err++; $display("FAIL rst_handshake: got %b want 10", {job_ready, res_valid}); end
      n_cmp++; if ({res_r, res_s} !== 512'h0) begin n_err++; $display("FAIL rst_result: got %h %h want 0", res_r, res_s); end
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      model_reset(1, 1, 8'hFF);
      submit(~SK_A, ~PK_A, ~MSG_A, lat, jr, ok);
      n_cmp++; if (ok !== 1'b1)        begin n_err++; $display("FAIL min_res_valid: no result within bound"); end
      n_cmp++; if (lat != 61)          begin n_err++; $display("FAIL min_latency: got %0d want 61", lat); end
      n_cmp++; if (jr !== 1'b0)        begin n_err++; $display("FAIL min_job_ready_drop: got %b want 0", jr); end
      n_cmp++; if ({res_r, res_s} !== {R_EXP, S_EXP}) begin n_err++; $display("FAIL min_result: got %h %h", res_r, res_s); end
      n_cmp++; if (trace.size() != 43) begin n_err++; $display("FAIL min_access_count: got %0d want 43", trace.size()); end
      accept();
   endtask

   initial begin
      test_reset();
      test_full_job();
      test_backpressure();
      test_error();
      test_timeout();
      test_reset_mid_rd();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ed25519_sign_host.md
# ed25519_sign_host

Bus-master sequencer that drives the `ed25519_sign` register interface from a streaming job port. It accepts {secret, public, message} as 256-bit words and performs the register transactions in order: poll ready, write 24 operand words, start, poll done, read 16 result words. It returns {R, S} on a result port. It sits between the system datapath and the signing core, replacing software-driven register access.

## Interface
- `POLL_LIMIT`, default 65535: maximum STATUS reads per poll phase before the job ends with a timeout.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `job_valid` in 1: job offered.
- `job_ready` out 1: high only in IDLE.
- `job_sk` in 256: secret key.
- `job_pk` in 256: public key.
- `job_msg` in 256: message.
- `res_valid` out 1: result held until accepted.
- `res_ready` in 1: result accepted.
- `res_r` out 256: R.
- `res_s` out 256: S.
- `res_err` out 1: core `error` seen during the job.
- `res_timeout` out 1: a poll phase exceeded `POLL_LIMIT`.
- `cs` out 1: core chip select.
- `we` out 1: core write enable.
- `address` out 8: core register address.
- `write_data` out 32: core write data.
- `read_data` in 32: core read data.
- `error` in 1: core access error.

## Operation
- Register map:
  - CTRL 0x08, with bit0 = start.
  - STATUS 0x09, with bit0 = ready and bit1 = done.
  - SECRET 0x10+k, PUBLIC 0x20+k, MESSAGE 0x30+k, R 0x40+k, S 0x50+k, for k = 0..7.
  - Word k is bits [32k+31:32k]. k=0 is sent or read first.
- Job handshake: a job is captured into internal 3×256 registers on `job_valid && job_ready`.
- FSM states:
  - IDLE → PRDY on job capture.
  - PRDY: read STATUS. If bit0 = 1 → WR. Otherwise stay.
  - WR: 24 writes in order SECRET0..7, PUBLIC0..7, MESSAGE0..7, using a 5-bit counter.
  - START: write CTRL = 0x00000001.
  - PDONE: read STATUS. If bit1 = 1 → RD. Otherwise stay.
  - RD: 16 reads in order R0..7, S0..7. Each read word is written into the `res_r`/`res_s` slice.
  - OUT: `res_valid` = 1. On `res_ready` → IDLE.
- Error handling: if `error` = 1 is sampled on any access cycle, set the sticky `res_err`, abandon the remaining accesses, and go to OUT. `res_r`/`res_s` hold whatever words were read so far; unread words are 0.
- Timeout handling: the poll counter resets on entering PRDY or PDONE. After `POLL_LIMIT` failed reads, set `res_timeout` and go to OUT.
- `res_r`, `res_s`, `res_err` and `res_timeout` are cleared on job capture.

## Timing
- Reset values: `cs`=0, `we`=0, `address`=0, `write_data`=0, `job_ready`=1, `res_valid`=0, all result outputs 0, state IDLE.
- Write access: one cycle with `cs`=1, `we`=1. Back-to-back writes have no gap.
- Read access: a 2-cycle slot.
  - Cycle A: `cs`=1, `we`=0, address driven.
  - Cycle B: `cs`=0. `read_data` is sampled at the end of cycle B.
  - `error` is sampled at the end of cycle A for both reads and writes.
- `cs` is never high for two consecutive cycles on reads.
- Minimum job latency, capture to `res_valid`, with ready and done each true on first poll: 2 (PRDY) + 24 (WR) + 1 (START) + 2 (PDONE) + 32 (RD) = 61 cycles.
- `job_ready` falls in the cycle after capture.
- `res_valid` rises in the cycle after the last read is sampled.
- Simultaneous `res_ready` and `res_valid`: the transfer completes. IDLE is reached the next cycle, and a new job may be captured that cycle.
- `rst_n` low mid-job: immediate return to reset values. No partial bus transaction is continued, and `cs` drops asynchronously.

## Structure
- Shared package `ed25519_pkg` holds:
  - Register address constants: ADDR_CTRL, ADDR_STATUS, ADDR_SECRET0, ADDR_PUBLIC0, ADDR_MESSAGE0, ADDR_R0, ADDR_S0.
  - STATUS bit indices.
  - CORE_NAME0/1 and CORE_VERSION.
  - The FSM state enum.
- Sub-module `ed25519_reg_port`: a single-access engine. It takes {start, we, addr, wdata} and returns {done, rdata, err}, and owns the 1-cycle write / 2-cycle read slot timing. The top FSM only sequences addresses.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles → `cs`=0, `job_ready`=1, `res_valid`=0, and all result outputs 0.
- Full job against a behavioural core model:
  - Stimulus: ready on the 3rd poll, done on the 10th poll, R word k = 0x11111111·(k+1), S word k = 0xA0000000+k.
  - Required: bus trace is 3 STATUS reads, then 24 writes to 0x10–0x17/0x20–0x27/0x30–0x37 with the correct 32-bit slices, then CTRL=1, then 10 STATUS reads, then reads of 0x40–0x57.
  - Required: `res_r` = 0x88888888_77777777_…_11111111, `res_s` word k = 0xA0000000+k, `res_err`=0.
- Backpressure: hold `res_ready`=0 for 20 cycles → `res_valid` and the result are stable. A new `job_valid` is not accepted.
- Error: the model asserts `error` on the write to 0x23 → no CTRL write occurs, `res_err`=1, `res_valid`=1, `res_r`=0.
- Timeout: with `POLL_LIMIT`=4, done is never set → exactly 4 STATUS reads in PDONE, then `res_timeout`=1 and no R/S reads.
- Reset mid-RD: deassert `rst_n` after the 5th R read → all outputs return to reset values. A following job completes correctly with the 61-cycle minimum latency.
